clk_div_gen: RTL and testbench

//  Parametrised clock-ratio generator for the PHY, driven by the fastest clock (clk_8f).

---
 rtl/clk_div_gen.sv | 66 ++++++
 tb/tb_clk_div_gen.sv | 115 +++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: aligned binary-divided clocks, programmable even divider and lock status from clk_8f
// Optional per-output rising-edge strobes (rise_stb) are built when CLK_GEN_STROBE_EN is defined.
module clk_div_gen #(
  parameter int NUM_OUT = 3,
  parameter int RATIO_W = 4
) (
  input  logic               clk_8f,
  input  logic               reset,
  input  logic               en,
  input  logic               sync,
  input  logic [RATIO_W-1:0] div_half,
  output logic [NUM_OUT-1:0] clk_div,
  output logic               clk_prog,
  output logic               locked
`ifdef CLK_GEN_STROBE_EN
  ,
  output logic [NUM_OUT-1:0] rise_stb
`endif
);
  logic [NUM_OUT-1:0] cnt_q, cnt_d, clk_div_q, clk_div_d, tog;
  logic [RATIO_W-1:0] pcnt_q, pcnt_d, half_lat_q, half_lat_d;
  logic               clk_prog_q, clk_prog_d, locked_q, locked_d, run_q, run_d;
  logic               restart, ptog;
  always_comb begin
    tog[0] = 1'b1;
    for (int i = 1; i < NUM_OUT; i++) tog[i] = tog[i-1] & ~cnt_q[i-1];
    // run_q remembers that the previous edge was already running, so only the first en=1 edge restarts
    restart    = en & (~run_q | sync);
    ptog       = pcnt_q == half_lat_q;
    run_d      = en;
    cnt_d      = !en ? '0 : restart ? NUM_OUT'(1) : cnt_q + 1'b1;
    clk_div_d  = !en ? '0 : restart ? '1 : clk_div_q ^ tog;
    clk_prog_d = !en ? 1'b0 : restart ? 1'b1 : clk_prog_q ^ ptog;
    pcnt_d     = (!en | restart | ptog) ? '0 : pcnt_q + 1'b1;
    half_lat_d = (en & (restart | (ptog & ~clk_prog_q))) ? div_half : half_lat_q;
    locked_d   = en & ~restart & (locked_q | (&cnt_q));
  end
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      cnt_q      <= '0;
      clk_div_q  <= '0;
      clk_prog_q <= 1'b0;
      pcnt_q     <= '0;
      half_lat_q <= '0;
      locked_q   <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_div_q  <= clk_div_d;
      clk_prog_q <= clk_prog_d;
      pcnt_q     <= pcnt_d;
      half_lat_q <= half_lat_d;
      locked_q   <= locked_d;
      run_q      <= run_d;
    end
  end
  assign clk_div  = clk_div_q;
  assign clk_prog = clk_prog_q;
  assign locked   = locked_q;
`ifdef CLK_GEN_STROBE_EN
  logic [NUM_OUT-1:0] rise_stb_q, rise_stb_d;
  always_comb rise_stb_d = clk_div_d & ~clk_div_q;
  always_ff @(posedge clk_8f) rise_stb_q <= !reset ? '0 : rise_stb_d;
  assign rise_stb = rise_stb_q;
`endif
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed checks of clk_div_gen with NUM_OUT=3, RATIO_W=4
module tb_clk_div_gen;
  logic       clk_8f = 1'b0;
  logic       reset, en, sync;
  logic [3:0] div_half;
  logic [2:0] clk_div;
  logic       clk_prog, locked;
  int         pass = 0, total = 0;
  logic [2:0] div_seq [8] = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};
  logic       prog_seq [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef CLK_GEN_STROBE_EN
  logic [2:0] rise_stb;
`endif
  clk_div_gen #(.NUM_OUT(3), .RATIO_W(4)) dut (
    .clk_8f(clk_8f), .reset(reset), .en(en), .sync(sync), .div_half(div_half),
    .clk_div(clk_div), .clk_prog(clk_prog), .locked(locked)
`ifdef CLK_GEN_STROBE_EN
    , .rise_stb(rise_stb)
`endif
  );
  always #5 clk_8f = ~clk_8f;
  task step;
    @(posedge clk_8f);
    #1;
  endtask
  task test_reset;
    reset = 1'b0; en = 1'b0; sync = 1'b0; div_half = 4'd3;
    repeat (3) step;
    total++; if (clk_div !== 3'b000) $display("FAIL reset_div: got %b expected 000", clk_div); else pass++;
    total++; if (clk_prog !== 1'b0) $display("FAIL reset_prog: got %b expected 0", clk_prog); else pass++;
    total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else pass++;
  endtask
  task test_binary;
    reset = 1'b1; en = 1'b1; div_half = 4'd3;
    for (int k = 1; k <= 16; k++) begin
      step;
      total++; if (clk_div !== div_seq[(k-1)%8]) $display("FAIL bin_div e%0d: got %b expected %b", k, clk_div, div_seq[(k-1)%8]); else pass++;
      total++; if (locked !== (k >= 8)) $display("FAIL bin_locked e%0d: got %b expected %b", k, locked, k >= 8); else pass++;
      total++; if (clk_prog !== (((k-1)/4)%2 == 0)) $display("FAIL bin_prog e%0d: got %b expected %b", k, clk_prog, ((k-1)/4)%2 == 0); else pass++;
    end
  endtask
  task test_prog;
    div_half = 4'd3; sync = 1'b1;
    step;
    sync = 1'b0;
    total++; if (clk_prog !== 1'b1) $display("FAIL prog_restart: got %b expected 1", clk_prog); else pass++;
    div_half = 4'd0;
    for (int k = 2; k <= 12; k++) begin
      step;
      total++; if (clk_prog !== prog_seq[k-1]) $display("FAIL prog_seq e%0d: got %b expected %b", k, clk_prog, prog_seq[k-1]); else pass++;
    end
  endtask
  task test_en_low;
    div_half = 4'd3; en = 1'b0; sync = 1'b1;
    repeat (5) begin
      step;
      total++; if ({clk_div, clk_prog, locked} !== 5'b0) $display("FAIL en_low: got div=%b prog=%b lock=%b expected all 0", clk_div, clk_prog, locked); else pass++;
    end
    sync = 1'b0; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step;
      total++; if (clk_div !== div_seq[k-1]) $display("FAIL en_div e%0d: got %b expected %b", k, clk_div, div_seq[k-1]); else pass++;
      total++; if (locked !== (k == 8)) $display("FAIL en_locked e%0d: got %b expected %b", k, locked, k == 8); else pass++;
    end
  endtask
  task test_sync;
    repeat (5) step;
    total++; if (clk_div !== 3'b011 || locked !== 1'b1) $display("FAIL sync_pre: got div=%b lock=%b expected 011/1", clk_div, locked); else pass++;
    sync = 1'b1;
    step;
    sync = 1'b0;
    total++; if ({clk_div, clk_prog, locked} !== 5'b11110) $display("FAIL sync_edge: got div=%b prog=%b lock=%b expected 111/1/0", clk_div, clk_prog, locked); else pass++;
    for (int k = 2; k <= 8; k++) begin
      step;
      total++; if (locked !== (k == 8)) $display("FAIL sync_locked e%0d: got %b expected %b", k, locked, k == 8); else pass++;
    end
  endtask
  task test_reset_priority;
    repeat (3) step;
    reset = 1'b0; en = 1'b1; sync = 1'b1;
    step;
    total++; if ({clk_div, clk_prog, locked} !== 5'b0) $display("FAIL rst_prio: got div=%b prog=%b lock=%b expected all 0", clk_div, clk_prog, locked); else pass++;
    reset = 1'b1; sync = 1'b0;
    step;
    total++; if (clk_div !== 3'b111 || clk_prog !== 1'b1) $display("FAIL rst_release: got div=%b prog=%b expected 111/1", clk_div, clk_prog); else pass++;
  endtask
`ifdef CLK_GEN_STROBE_EN
  task test_strobe;
    logic [2:0] e;
    en = 1'b0;
    step;
    total++; if (rise_stb !== 3'b000) $display("FAIL stb_off: got %b expected 000", rise_stb); else pass++;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step;
      e = {k%8 == 1, k%4 == 1, k%2 == 1};
      total++; if (rise_stb !== e) $display("FAIL stb e%0d: got %b expected %b", k, rise_stb, e); else pass++;
    end
  endtask
`endif
  initial begin
    reset = 1'b0; en = 1'b0; sync = 1'b0; div_half = '0;
    test_reset;
    test_binary;
    test_prog;
    test_en_low;
    test_sync;
    test_reset_priority;
`ifdef CLK_GEN_STROBE_EN
    test_strobe;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
